// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: holds mem/periph/cpu resets, then releases them in order.
// Optional button debounce is enabled by defining RST_SEQ_DEBOUNCE_EN.
module rst_seq_ctrl #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned PERIPH_DLY  = 8,
   parameter int unsigned CPU_DLY     = 4,
   parameter int unsigned DEB_CYCLES  = 1024
) (
   input  logic       clk,
   input  logic       reset_in,
   input  logic       btn_n,
   input  logic       sw_req,
   input  logic       cause_clr,
   output logic       mem_rst,
   output logic       periph_rst,
   output logic       cpu_rst,
   output logic       done,
   output logic [2:0] cause
);

   localparam int unsigned MAX_AB  = (HOLD_CYCLES > PERIPH_DLY) ? HOLD_CYCLES : PERIPH_DLY;
   localparam int unsigned MAX_DLY = (MAX_AB > CPU_DLY) ? MAX_AB : CPU_DLY;
   localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);

   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] PERIPH_LOAD = CNT_W'(PERIPH_DLY - 1);
   localparam logic [CNT_W-1:0] CPU_LOAD    = CNT_W'(CPU_DLY - 1);

   typedef enum logic [1:0] {
      StHold,
      StMemUp,
      StPeriphUp,
      StRun
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_q;
   logic [1:0]       btn_sync;
   logic             btn_req;
   logic             req;

   always_ff @(posedge clk) begin
      if (reset_in) begin
         btn_sync <= 2'b11;
      end else begin
         btn_sync <= {btn_sync[0], btn_n};
      end
   end

`ifdef RST_SEQ_DEBOUNCE_EN
   localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

   logic [DEB_W-1:0] deb_cnt;
   logic             btn_req_q;

   // The filtered level flips only after DEB_CYCLES consecutive samples disagree with it.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         deb_cnt   <= '0;
         btn_req_q <= 1'b0;
      end else if ((~btn_sync[1]) == btn_req_q) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
         deb_cnt   <= '0;
         btn_req_q <= ~btn_sync[1];
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   assign btn_req = btn_req_q;
`else
   logic unused_deb_cfg;
   assign unused_deb_cfg = ^DEB_CYCLES;
   assign btn_req = ~btn_sync[1];
`endif

   assign req = reset_in | btn_req | sw_req;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (req) begin
         state_d = StHold;
         cnt_d   = HOLD_LOAD;
      end else begin
         unique case (state_q)
            StHold: begin
               // The first request-free edge still belongs to the restart window.
               if (req_q) begin
                  cnt_d = HOLD_LOAD;
               end else if (cnt_q == '0) begin
                  state_d = StMemUp;
                  cnt_d   = PERIPH_LOAD;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StMemUp: begin
               if (cnt_q == '0) begin
                  state_d = StPeriphUp;
                  cnt_d   = CPU_LOAD;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StPeriphUp: begin
               if (cnt_q == '0) begin
                  state_d = StRun;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StRun: begin
               state_d = StRun;
            end
            default: begin
               state_d = StHold;
               cnt_d   = HOLD_LOAD;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_in) begin
         state_q    <= StHold;
         cnt_q      <= HOLD_LOAD;
         req_q      <= 1'b1;
         mem_rst    <= 1'b1;
         periph_rst <= 1'b1;
         cpu_rst    <= 1'b1;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req;
         mem_rst    <= (state_d == StHold);
         periph_rst <= (state_d == StHold) || (state_d == StMemUp);
         cpu_rst    <= (state_d != StRun);
         done       <= (state_d == StRun);
      end
   end

   // Set beats clear; the POR bit is only ever set.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         cause <= 3'b001;
      end else begin
         cause[0] <= cause[0];
         cause[1] <= btn_req | (cause[1] & ~cause_clr);
         cause[2] <= sw_req | (cause[2] & ~cause_clr);
      end
   end

endmodule
